// File: rtl/clfsr_decrypt.sv
// Streaming CLFSR frame decryptor: pairs each keystream triple with the ciphertext pixel
// at the same address, XORs them, and queues plaintext in a 4-entry FWFT FIFO.
module clfsr_decrypt #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [7:0]        R_random,
    input  logic [7:0]        G_random,
    input  logic [7:0]        B_random,
    output logic              ct_rd_en,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        R_ct,
    input  logic [7:0]        G_ct,
    input  logic [7:0]        B_ct,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        R_plain,
    output logic [7:0]        G_plain,
    output logic [7:0]        B_plain,
    output logic              pix_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshakes: a keystream triple moves when ks_valid && ks_ready; a plaintext
    // pixel moves when pix_valid && pix_ready. Neither ready depends on its own valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] hold_addr_q;
    logic              inflight_q;
    logic [23:0]       key_q;
    logic              key_last_q;
    logic [24:0]       fifo_q [4];
    logic [1:0]        wr_ptr_q;
    logic [1:0]        rd_ptr_q;
    logic [2:0]        count_q;

    logic [2:0]        occ;
    logic              xfer;
    logic              is_last;
    logic              push;
    logic              pop;
    logic [24:0]       head;

    // Reserving room for the in-flight read keeps the FIFO from ever overflowing.
    assign occ      = count_q + {2'b00, inflight_q};
    assign ks_ready = (state_q == S_RUN) && (occ <= 3'd2);
    assign xfer     = ks_valid && ks_ready;
    assign is_last  = (addr_q == LAST_ADDR);
    assign ct_rd_en = xfer;
    assign ct_addr  = xfer ? addr_q : hold_addr_q;

    assign head      = fifo_q[rd_ptr_q];
    assign pix_valid = (count_q != 3'd0);
    assign R_plain   = head[24:17];
    assign G_plain   = head[16:9];
    assign B_plain   = head[8:1];
    assign pix_last  = pix_valid && head[0];
    assign push      = inflight_q;
    assign pop       = pix_valid && pix_ready;

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (is_last) state_d = S_DRAIN;
                    else         addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (pop && head[0]) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            hold_addr_q <= '0;
            inflight_q  <= 1'b0;
            key_q       <= '0;
            key_last_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= xfer;
            if (xfer) begin
                key_q       <= {R_random, G_random, B_random};
                key_last_q  <= is_last;
                hold_addr_q <= addr_q;
            end
            // RAM data returns one cycle after the read; combine it with the held key.
            if (push) begin
                fifo_q[wr_ptr_q] <= {R_ct ^ key_q[23:16], G_ct ^ key_q[15:8],
                                     B_ct ^ key_q[7:0], key_last_q};
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
